// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the mul/div sequencer state type.
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Funct3[2] separates the divide group from the multiply group.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on magnitudes.
// Multiply: {acc, lo} is the product register, lo initially holds the multiplier.
// Divide:   acc is the partial remainder, lo shifts the dividend out and quotient in.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] op,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          ge;

  // Single datapath step, selected by operation group.
  always_comb begin
    sum   = {1'b0, acc} + (lo[0] ? {1'b0, op} : '0);
    trial = {acc, lo[XLEN-1]};
    diff  = trial - {1'b0, op};
    ge    = (trial >= {1'b0, op});
    if (is_div) begin
      acc_nxt = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ge};
    end else begin
      // Carry out of the add becomes the new top bit after the right shift.
      acc_nxt = sum[XLEN:1];
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: IDLE -> CALC (XLEN cycles) -> FIX -> DONE,
// with a direct IDLE -> DONE path for divide-by-zero and signed overflow.
module muldiv_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  op_q, op_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             a_signed, b_signed, sign_a, sign_b, neg_in;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic             div_zero, div_ovf, fast;
  logic [XLEN-1:0]  fast_res;
  logic [XLEN-1:0]  step_acc, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]  fix_res;

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div (f3_is_div(f3_q)),
    .acc    (acc_q),
    .lo     (lo_q),
    .op     (op_q),
    .acc_nxt(step_acc),
    .lo_nxt (step_lo)
  );

  // Decode incoming operands: magnitudes, result sign and fast-path results.
  always_comb begin
    a_signed = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
               (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    b_signed = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    sign_a   = a_signed & SrcA[XLEN-1];
    sign_b   = b_signed & SrcB[XLEN-1];
    abs_a    = sign_a ? (~SrcA + 1'b1) : SrcA;
    abs_b    = sign_b ? (~SrcB + 1'b1) : SrcB;

    neg_in = 1'b0;
    case (Funct3)
      F3_MULH, F3_MULHSU, F3_DIV: neg_in = sign_a ^ sign_b;
      F3_REM:                     neg_in = sign_a;
      default:                    neg_in = 1'b0;
    endcase

    div_zero = f3_is_div(Funct3) && (SrcB == '0);
    div_ovf  = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
               (SrcA == MinNeg) && (SrcB == '1);
    fast     = div_zero || div_ovf;

    fast_res = '0;
    if (div_zero) begin
      fast_res = Funct3[1] ? SrcA : '1;
    end else if (div_ovf) begin
      fast_res = Funct3[1] ? '0 : MinNeg;
    end
  end

  // Final sign correction and word selection.
  always_comb begin
    prod    = {acc_q, lo_q};
    prod_s  = neg_q ? (~prod + 1'b1) : prod;
    fix_res = '0;
    case (f3_q)
      F3_MUL:                        fix_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_res = neg_q ? (~lo_q + 1'b1) : lo_q;
      default:                       fix_res = neg_q ? (~acc_q + 1'b1) : acc_q;
    endcase
  end

  // Next-state, datapath updates and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    result_d = result_q;
    stall    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          stall = 1'b1;
          f3_d  = Funct3;
          neg_d = neg_in;
          // The step adds/subtracts op; lo starts with the operand that gets shifted out.
          op_d  = f3_is_div(Funct3) ? abs_b : abs_a;
          lo_d  = f3_is_div(Funct3) ? abs_a : abs_b;
          acc_d = '0;
          if (fast) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        acc_d = step_acc;
        lo_d  = step_lo;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        stall    = 1'b1;
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
      done     = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at issue, checked on done.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Funct3(Funct3),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result", Result, exp_q.pop_front());
    end
  end

  // Issue one op at cycle 0, then check stall profile and done latency.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int cyc;
    logic stall_bad;
    @(posedge clk); #1;
    start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    exp_q.push_back(exp);
    @(negedge clk);
    stall_bad = (stall !== 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || cyc > 100) break;
      if (stall !== 1'b1) stall_bad = 1'b1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("stall_profile", {31'b0, stall_bad}, 32'd0);
    check("stall_at_done", {31'b0, stall}, 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    Funct3 = 3'b000; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", Result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);  // MUL 7 * -3
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);  // MULHU
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);  // MULH
    do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34);  // MULHSU -1 * 2
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);  // DIV -7 / 2
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);  // REM -7 % 2
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 34);  // DIVU
    do_op(3'b111, 32'd100, 32'd7, 32'd2, 34);  // REMU
    do_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);  // DIVU by zero
    do_op(3'b110, 32'd5, 32'd0, 32'd5, 1);  // REM by zero
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);  // REM overflow
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);  // DIV overflow

    // Start pulses during CALC must be ignored.
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
    exp_q.push_back(32'd14);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || cyc > 100) break;
      if (cyc == 5) begin
        start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
      end
      if (cyc == 7) start = 1'b0;
      cyc++;
    end
    check("ignore_latency", 32'(cyc), 32'd34);
    repeat (40) @(negedge clk);
    check("ignore_idle", {31'b0, busy}, 32'd0);

    // Flush at cycle 10 of a DIV: no done, Result keeps 14.
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b100; SrcA = 32'hFFFF_FFF9; SrcB = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_c10_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", Result, 32'd14);
    repeat (40) @(negedge clk);
    check("flush_result_held", Result, 32'd14);

    // Reset mid-CALC, then a clean MUL.
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b000; SrcA = 32'd5; SrcB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_stall", {31'b0, stall}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", Result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(3'b000, 32'd3, 32'd4, 32'd12, 34);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide ops, sitting in the EX stage beside the ALU.
- Accepts operands when the Controller decodes an M-extension R-type (Funct7 = 0000001) and runs an iterative shift-add multiply or restoring divide.
- Stalls the pipeline while busy, then presents the result for one cycle with a done pulse.
- Handles RISC-V divide-by-zero and signed-overflow corner cases in a fast path.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- Funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  XLEN  rs1 (multiplicand/dividend)
- SrcB  input  XLEN  rs2 (multiplier/divisor)
- flush  input  1  abort in-flight op (branch mispredict/pipeline flush)
- stall  output  1  hold IF/ID/EX pipeline registers
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse, Result valid
- Result  output  XLEN  final result, held until next accepted start

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state = IDLE, stall = 0, busy = 0, done = 0, Result = 0, counter = 0.
- States and transitions:
  - IDLE: on start && !flush, latch Funct3, |SrcA| and |SrcB| (per signedness), and the result sign flag. Go to DONE if fast path, else CALC.
  - CALC: one iteration per cycle, XLEN cycles (counter counts XLEN-1 down to 0). Go to FIX when counter == 0.
  - FIX: apply two's-complement negation if the sign flag is set; select the high or low word (MUL vs MULH*) or quotient vs remainder; register Result. Go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: start in cycle 0 -> done in cycle XLEN+2 (34 for XLEN = 32). Fast path -> done in cycle 1.
- stall (combinational) = (IDLE && start && !flush) || CALC || FIX. stall is low in DONE so the instruction advances with Result.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: SrcA signed, SrcB unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV/REM: quotient sign = signA ^ signB; remainder sign = signA.
- Multiply: 2*XLEN-bit product register; add |A| when multiplier LSB = 1, then shift right.
- Divide: restoring, XLEN-bit remainder plus quotient shift register. Subtract when the trial remainder >= divisor.
- Fast path (IDLE -> DONE, Result written on the transition):
  - Divisor == 0: DIV/DIVU -> all ones; REM/REMU -> SrcA.
  - DIV/REM with SrcA = 0x80000000 and SrcB = 0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
- start while not IDLE: ignored, no queuing.
- flush: in any state, next state = IDLE with done = 0 and Result unchanged. flush has priority over start in the same cycle.
- reset mid-operation: same as the reset values above; the next start begins cleanly.
- Arithmetic: all ops are mod 2^XLEN, no exceptions raised.

Decomposition:
- Shared package riscv_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t
  - Funct3 localparams (F3_MUL … F3_REMU)
  - FUNCT7_MULDIV = 7'b0000001
- One sub-module, muldiv_step: combinational single iteration (mul add/shift or div trial-subtract/shift). The sequencer owns the FSM, counter, sign handling and Result register.

Test Plan:
- MUL SrcA = 7, SrcB = 0xFFFFFFFD (-3), start at cycle 0 -> stall high cycles 0–33, done = 1 at cycle 34, Result = 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> Result = 0xFFFFFFFE. MULH same operands -> Result = 0x00000000.
- DIV -7 (0xFFFFFFF9) / 2 -> Result = 0xFFFFFFFD. REM same operands -> Result = 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2.
- DIVU 5 / 0 -> done at cycle 1, Result = 0xFFFFFFFF. REM 5 / 0 -> Result = 5. DIV 0x80000000 / 0xFFFFFFFF -> Result = 0x80000000 at cycle 1.
- Abort and ignore: flush at cycle 10 of a DIV -> IDLE at cycle 11, no done pulse, stall low, Result unchanged. start pulses during CALC are ignored.
- reset asserted mid-CALC -> all outputs 0 next cycle. A following MUL 3×4 completes normally with Result = 12.
